// File: rtl/edge_cfg_pkg.sv
// Shared types for edge_cfg_sequencer: FSM state encoding and the
// {edge, horiz} configuration pair used for pending and committed settings.
package edge_cfg_pkg;

  localparam int CNT_W_DEF = 11;

  typedef enum logic [1:0] {
    SYNC       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } state_e;

  typedef struct packed {
    logic edge_on;
    logic horiz;
  } cfg_t;

  function automatic logic cfg_differs(input cfg_t a, input cfg_t b);
    return (a.edge_on != b.edge_on) | (a.horiz != b.horiz);
  endfunction

endpackage

// File: rtl/edge_key_debounce.sv
// Two-flop synchronizer plus stability counter for one raw async input.
// level_o changes after DEBOUNCE_CYC identical samples; press_o pulses on an accepted fall.
module edge_key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
  parameter logic        RST_LEVEL    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q;
  logic        press_q;
  logic [19:0] cnt_q;

  // cnt_q counts consecutive synchronized samples that disagree with level_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= RST_LEVEL;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEBOUNCE_CYC - 20'd1) begin
        level_q <= sync2_q;
        press_q <= ~sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 20'd1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/edge_cfg_sequencer.sv
// Frame-synchronous pixel coordinate sequencer with frame-start config commit.
// Optional EDGE_CFG_FRAME_CNT_EN adds oFrameCnt and masks oCfgPending for two warm-up frames.
module edge_cfg_sequencer
  import edge_cfg_pkg::*;
#(
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 960,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
  parameter int          CNT_W        = CNT_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic             iKEY_EDGE,
  input  logic             iSW_HORIZ,
  output logic [CNT_W-1:0] oX_Cont,
  output logic [CNT_W-1:0] oY_Cont,
  output logic             oEdgeDetect,
  output logic             oIsHorizontalEdge,
  output logic             oFrameStart,
`ifdef EDGE_CFG_FRAME_CNT_EN
  output logic [15:0]      oFrameCnt,
`endif
  output logic             oCfgPending
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  state_e           state_q;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  cfg_t             pending_q;
  cfg_t             pending_d;
  cfg_t             committed_q;
  logic             frame_start_q;
  logic             commit;
  logic             key_press;
  logic             sw_level;
  logic             key_level_unused;
  logic             sw_press_unused;

  edge_key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .RST_LEVEL    (1'b1)
  ) u_key_db (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .raw_i   (iKEY_EDGE),
    .level_o (key_level_unused),
    .press_o (key_press)
  );

  edge_key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .RST_LEVEL    (1'b0)
  ) u_sw_db (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .raw_i   (iSW_HORIZ),
    .level_o (sw_level),
    .press_o (sw_press_unused)
  );

  // The commit reads pending_d so a press landing on the commit cycle is included.
  always_comb begin
    pending_d         = pending_q;
    pending_d.edge_on = pending_q.edge_on ^ key_press;
    pending_d.horiz   = sw_level;
  end

  assign commit = (state_q == WAIT_FRAME) && iFVAL;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q       <= SYNC;
      x_q           <= '0;
      y_q           <= '0;
      pending_q     <= '0;
      committed_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      frame_start_q <= 1'b0;
      case (state_q)
        SYNC: begin
          if (!iFVAL) state_q <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (commit) begin
            state_q       <= ACTIVE;
            committed_q   <= pending_d;
            frame_start_q <= 1'b1;
            x_q           <= '0;
            y_q           <= '0;
          end
        end
        ACTIVE: begin
          if (!iFVAL) begin
            state_q <= WAIT_FRAME;
            x_q     <= '0;
            y_q     <= '0;
          end else if (iDVAL) begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q != Y_LAST) y_q <= y_q + CNT_W'(1);
            end else begin
              x_q <= x_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign oX_Cont           = x_q;
  assign oY_Cont           = y_q;
  assign oEdgeDetect       = committed_q.edge_on;
  assign oIsHorizontalEdge = committed_q.horiz;
  assign oFrameStart       = frame_start_q;

`ifdef EDGE_CFG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        warm_q;

  // warm_q rises as the third frame commits and stays set until reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      frame_cnt_q <= '0;
      warm_q      <= 1'b0;
    end else if (commit) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
      if (frame_cnt_q == 16'd2) warm_q <= 1'b1;
    end
  end

  assign oFrameCnt   = frame_cnt_q;
  assign oCfgPending = cfg_differs(pending_q, committed_q) & warm_q;
`else
  assign oCfgPending = cfg_differs(pending_q, committed_q);
`endif

endmodule

// File: doc/edge_cfg_sequencer.md
Name: edge_cfg_sequencer

Overview:
Frame-synchronous sequencer and configuration controller for the Bayer-to-RGB / edge-detect pixel path. It generates the iX_Cont/iY_Cont coordinates the datapath consumes from the capture-side iFVAL/iDVAL stream. It also debounces the user button and switch, and commits edge-detect enable and orientation only at frame starts, so a frame is never processed under mixed settings.

Parameters:
H_ACTIVE, 1280, active pixels per line (valid iDVAL beats before X wraps)
V_ACTIVE, 960, active lines per frame (Y saturates at V_ACTIVE-1)
DEBOUNCE_CYC, 20'd500000, cycles the synchronized input must stay stable before being accepted
CNT_W, 11, coordinate counter width

Ports:
iCLK  input  1  pixel clock, single clock domain
iRST  input  1  synchronous reset, active-high
iFVAL  input  1  frame valid from capture
iDVAL  input  1  pixel valid from capture
iKEY_EDGE  input  1  raw button, asynchronous, active-low press
iSW_HORIZ  input  1  raw switch, asynchronous, 1 = horizontal edges
oX_Cont  output  CNT_W  column of the current iDVAL beat
oY_Cont  output  CNT_W  row of the current iDVAL beat
oEdgeDetect  output  1  committed edge-detect enable
oIsHorizontalEdge  output  1  committed orientation
oFrameStart  output  1  one-cycle pulse on the frame commit cycle
oCfgPending  output  1  pending configuration differs from committed configuration

Behaviour:
- Reset values: all outputs 0; state = SYNC; pending config = 0; debouncers cleared. Sampled sync flops are set to 1 (idle, unpressed) on reset.
- Input conditioning:
  - Each of iKEY_EDGE and iSW_HORIZ passes through a 2-flop synchronizer, then a stability counter.
  - A value is accepted after DEBOUNCE_CYC consecutive identical samples.
  - An accepted key falling edge (press) toggles pending_edge.
  - The accepted switch level is copied to pending_horiz.
- FSM states:
  - SYNC: wait for iFVAL=0. Prevents counting a partial frame after reset.
  - WAIT_FRAME: wait for iFVAL=1.
  - ACTIVE: count pixels while iFVAL=1.
- Transitions:
  - SYNC->WAIT_FRAME when iFVAL=0.
  - WAIT_FRAME->ACTIVE on the first cycle iFVAL=1. That cycle is the commit cycle: oEdgeDetect<=pending_edge, oIsHorizontalEdge<=pending_horiz, oFrameStart=1 for exactly that cycle, X=Y=0.
  - ACTIVE->WAIT_FRAME on iFVAL=0. X and Y are cleared on that cycle.
- Counting in ACTIVE:
  - oX_Cont/oY_Cont are combinational from the count registers, so they are valid in the same cycle as the iDVAL beat they label.
  - On iDVAL=1: if X==H_ACTIVE-1, X<=0 and Y<=Y+1 (Y saturates at V_ACTIVE-1); otherwise X<=X+1.
  - iDVAL with iFVAL=0, or in SYNC/WAIT_FRAME, is ignored.
  - A line ending early (fewer than H_ACTIVE beats) does not advance Y. Counting is beat-based only.
- Config commit rules:
  - A key press during ACTIVE updates only pending_edge. It takes effect at the next commit.
  - A press landing in the same cycle as the commit is committed in that same commit, i.e. the new pending value is used.
  - oCfgPending = (pending_edge != oEdgeDetect) | (pending_horiz != oIsHorizontalEdge).
- Reset mid-frame: all state returns to reset values next cycle; the FSM re-enters SYNC, and the rest of the interrupted frame is not counted.

Optional Feature:
EDGE_CFG_FRAME_CNT_EN
- Defined: adds output oFrameCnt [15:0], reset 0, incremented on each oFrameStart and wrapping at 16'hFFFF->0. The count is also gated into oCfgPending, which is suppressed for the first 2 frames after reset so that sensor warm-up frames never show a pending change.
- Undefined: no oFrameCnt port and no suppression logic.

Decomposition:
- Package edge_cfg_pkg: state enum (SYNC, WAIT_FRAME, ACTIVE); CNT_W default; a cfg_t struct {edge, horiz}.
- Sub-module edge_key_debounce (synchronizer + stability counter, parameter DEBOUNCE_CYC, outputs level and press pulse), instantiated twice.

Test Plan:
- Reset, then start streaming mid-frame (iFVAL=1 at release): no counting until iFVAL falls and rises again; the first oFrameStart comes at that rise, oX_Cont=0, oY_Cont=0.
- One frame of H_ACTIVE=8, V_ACTIVE=4 (DVAL bursts of 8): X runs 0..7 per line, Y runs 0..3; a 5th burst keeps Y=3; iFVAL fall clears X and Y.
- Key held low for DEBOUNCE_CYC-1 cycles, then released: no toggle. Held low for DEBOUNCE_CYC cycles: pending_edge=1, oCfgPending=1 and oEdgeDetect=0 until the next frame start, then oEdgeDetect=1 and oCfgPending=0.
- Switch flipped to 1 mid-ACTIVE: oIsHorizontalEdge stays 0 for the rest of the frame and becomes 1 on the next oFrameStart cycle.
- iRST asserted for 1 cycle in the middle of a line: next cycle all outputs are 0 and the FSM is in SYNC; iDVAL beats are ignored until iFVAL low then high.
- With EDGE_CFG_FRAME_CNT_EN defined: 3 frames give oFrameCnt=3, and oCfgPending stays 0 during frames 1-2 even when a key press occurs.
